// File: rtl/letc_core_scoreboard.sv
// Register scoreboard: per-register pending-writer counters, issue gating and a RUN/DRAIN
// flush FSM that waits for every in-flight writer to be released.
module letc_core_scoreboard #(
   parameter int unsigned MAX_PENDING = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [4:0] i_rs1_idx,
   input  logic [4:0] i_rs2_idx,
   input  logic       i_issue_valid,
   input  logic       i_issue_rd_we,
   input  logic [4:0] i_issue_rd_idx,
   output logic       o_issue_ready,
   input  logic       i_release_valid,
   input  logic [4:0] i_release_rd_idx,
   input  logic       i_flush,
   output logic       o_rs1_hazard,
   output logic       o_rs2_hazard,
   output logic       o_stall_d,
   output logic       o_draining,
   output logic [6:0] o_inflight_cnt,
   output logic       o_err
);

   localparam int unsigned CntW = $clog2(MAX_PENDING + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MAX_PENDING);

   typedef enum logic {StRun, StDrain} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q [32];
   logic [CntW-1:0] cnt_d [32];
   logic [6:0]      inflight_q, inflight_d;
   logic            err_q, err_d;

   logic rd_nz, rel_nz, same_reg, rd_full, inc, dec;

   assign rd_nz    = (i_issue_rd_idx != 5'd0);
   assign rel_nz   = (i_release_rd_idx != 5'd0);
   assign same_reg = (i_issue_rd_idx == i_release_rd_idx);

   // A same-cycle release of the destination frees a slot for the new writer.
   assign rd_full = i_issue_rd_we & rd_nz & (cnt_q[i_issue_rd_idx] == CntMax)
                    & ~(i_release_valid & same_reg);

   assign o_issue_ready = (state_q == StRun) & ~i_flush & ~rd_full;
   assign o_rs1_hazard  = (i_rs1_idx != 5'd0) & (cnt_q[i_rs1_idx] != '0);
   assign o_rs2_hazard  = (i_rs2_idx != 5'd0) & (cnt_q[i_rs2_idx] != '0);
   assign o_stall_d     = i_issue_valid & (o_rs1_hazard | o_rs2_hazard | ~o_issue_ready);
   assign o_draining    = (state_q == StDrain);
   assign o_inflight_cnt = inflight_q;
   assign o_err          = err_q;

   assign inc = i_issue_valid & o_issue_ready & i_issue_rd_we & rd_nz;
   assign dec = i_release_valid & rel_nz & (cnt_q[i_release_rd_idx] != '0);

   always_comb begin
      cnt_d      = cnt_q;
      inflight_d = inflight_q;
      err_d      = err_q | (i_release_valid & rel_nz & (cnt_q[i_release_rd_idx] == '0));
      if (inc && !(dec && same_reg)) begin
         cnt_d[i_issue_rd_idx] = cnt_q[i_issue_rd_idx] + CntW'(1);
      end
      if (dec && !(inc && same_reg)) begin
         cnt_d[i_release_rd_idx] = cnt_q[i_release_rd_idx] - CntW'(1);
      end
      if (inc && !dec) begin
         inflight_d = inflight_q + 7'd1;
      end else if (dec && !inc) begin
         inflight_d = inflight_q - 7'd1;
      end
      cnt_d[0] = '0;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (i_flush) state_d = StDrain;
         StDrain: if ((inflight_q == 7'd0) && !i_flush) state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StRun;
         inflight_q <= 7'd0;
         err_q      <= 1'b0;
         for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
         for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      end
   end

endmodule

// File: tb/tb_letc_core_scoreboard.sv
// Directed bench for letc_core_scoreboard with MAX_PENDING=3.
module tb_letc_core_scoreboard;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [4:0] i_rs1_idx, i_rs2_idx, i_issue_rd_idx, i_release_rd_idx;
   logic       i_issue_valid, i_issue_rd_we, i_release_valid, i_flush;
   logic       o_issue_ready, o_rs1_hazard, o_rs2_hazard, o_stall_d, o_draining, o_err;
   logic [6:0] o_inflight_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 i_clk = ~i_clk;

   letc_core_scoreboard #(.MAX_PENDING(3)) dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_rs1_idx        (i_rs1_idx),
      .i_rs2_idx        (i_rs2_idx),
      .i_issue_valid    (i_issue_valid),
      .i_issue_rd_we    (i_issue_rd_we),
      .i_issue_rd_idx   (i_issue_rd_idx),
      .o_issue_ready    (o_issue_ready),
      .i_release_valid  (i_release_valid),
      .i_release_rd_idx (i_release_rd_idx),
      .i_flush          (i_flush),
      .o_rs1_hazard     (o_rs1_hazard),
      .o_rs2_hazard     (o_rs2_hazard),
      .o_stall_d        (o_stall_d),
      .o_draining       (o_draining),
      .o_inflight_cnt   (o_inflight_cnt),
      .o_err            (o_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"},    {31'd0, o_issue_ready},  32'd1);
      chk({tag, "_rs1_haz"},  {31'd0, o_rs1_hazard},   32'd0);
      chk({tag, "_rs2_haz"},  {31'd0, o_rs2_hazard},   32'd0);
      chk({tag, "_stall"},    {31'd0, o_stall_d},      32'd0);
      chk({tag, "_draining"}, {31'd0, o_draining},     32'd0);
      chk({tag, "_inflight"}, {25'd0, o_inflight_cnt}, 32'd0);
      chk({tag, "_err"},      {31'd0, o_err},          32'd0);
   endtask

   task automatic issue(input logic [4:0] rd);
      i_issue_valid = 1'b1; i_issue_rd_we = 1'b1; i_issue_rd_idx = rd;
      tick();
      i_issue_valid = 1'b0; i_issue_rd_we = 1'b0;
   endtask

   task automatic release_rd(input logic [4:0] rd);
      i_release_valid = 1'b1; i_release_rd_idx = rd;
      tick();
      i_release_valid = 1'b0;
   endtask

   initial begin
      i_rst_n = 1'b0; i_rs1_idx = '0; i_rs2_idx = '0; i_issue_valid = 1'b0;
      i_issue_rd_we = 1'b0; i_issue_rd_idx = '0; i_release_valid = 1'b0;
      i_release_rd_idx = '0; i_flush = 1'b0;
      #2;
      chk_reset_vals("reset");
      tick();
      i_rst_n = 1'b1;

      // RAW hazard on rd=5, cleared by release one cycle later
      i_issue_valid = 1'b1; i_issue_rd_we = 1'b1; i_issue_rd_idx = 5'd5;
      #1;
      chk("raw_issue_ready", {31'd0, o_issue_ready}, 32'd1);
      tick();
      i_issue_rd_we = 1'b0; i_rs1_idx = 5'd5;
      #1;
      chk("raw_rs1_haz", {31'd0, o_rs1_hazard}, 32'd1);
      chk("raw_stall", {31'd0, o_stall_d}, 32'd1);
      chk("raw_inflight", {25'd0, o_inflight_cnt}, 32'd1);
      chk("raw_rs2_clean", {31'd0, o_rs2_hazard}, 32'd0);
      i_issue_valid = 1'b0; i_release_valid = 1'b1; i_release_rd_idx = 5'd5;
      #1;
      chk("raw_no_bypass", {31'd0, o_rs1_hazard}, 32'd1);
      tick();
      i_release_valid = 1'b0;
      #1;
      chk("raw_cleared", {31'd0, o_rs1_hazard}, 32'd0);
      chk("raw_inflight0", {25'd0, o_inflight_cnt}, 32'd0);
      i_rs1_idx = 5'd0;

      // x0 is never tracked
      i_issue_valid = 1'b1; i_issue_rd_we = 1'b1; i_issue_rd_idx = 5'd0;
      #1;
      chk("x0_haz", {31'd0, o_rs1_hazard}, 32'd0);
      chk("x0_stall", {31'd0, o_stall_d}, 32'd0);
      tick();
      i_issue_valid = 1'b0; i_issue_rd_we = 1'b0;
      #1;
      chk("x0_inflight", {25'd0, o_inflight_cnt}, 32'd0);

      // Saturate rd=7 at MAX_PENDING, then issue alongside a same-cycle release
      issue(5'd7); issue(5'd7); issue(5'd7);
      i_issue_valid = 1'b1; i_issue_rd_we = 1'b1; i_issue_rd_idx = 5'd7;
      #1;
      chk("sat_inflight3", {25'd0, o_inflight_cnt}, 32'd3);
      chk("sat_ready0", {31'd0, o_issue_ready}, 32'd0);
      chk("sat_stall", {31'd0, o_stall_d}, 32'd1);
      i_release_valid = 1'b1; i_release_rd_idx = 5'd7;
      #1;
      chk("sat_rel_ready1", {31'd0, o_issue_ready}, 32'd1);
      tick();
      i_release_valid = 1'b0;
      #1;
      chk("sat_still_full", {31'd0, o_issue_ready}, 32'd0);
      chk("sat_net_zero", {25'd0, o_inflight_cnt}, 32'd3);
      i_issue_valid = 1'b0; i_issue_rd_we = 1'b0;
      release_rd(5'd7); release_rd(5'd7); release_rd(5'd7);
      #1;
      chk("sat_drained", {25'd0, o_inflight_cnt}, 32'd0);
      chk("sat_no_err", {31'd0, o_err}, 32'd0);

      // Release of x0 is silently ignored
      release_rd(5'd0);
      #1;
      chk("x0_rel_err", {31'd0, o_err}, 32'd0);

      // Flush with two writers pending
      issue(5'd3); issue(5'd9);
      i_flush = 1'b1;
      #1;
      chk("fl_ready_flush", {31'd0, o_issue_ready}, 32'd0);
      tick();
      i_flush = 1'b0;
      i_issue_valid = 1'b1; i_issue_rd_we = 1'b1; i_issue_rd_idx = 5'd1;
      #1;
      chk("fl_draining", {31'd0, o_draining}, 32'd1);
      chk("fl_ready0", {31'd0, o_issue_ready}, 32'd0);
      chk("fl_stall", {31'd0, o_stall_d}, 32'd1);
      tick();
      i_issue_valid = 1'b0; i_issue_rd_we = 1'b0;
      #1;
      chk("fl_no_issue", {25'd0, o_inflight_cnt}, 32'd2);
      release_rd(5'd3);
      #1;
      chk("fl_inflight1", {25'd0, o_inflight_cnt}, 32'd1);
      chk("fl_still_drain", {31'd0, o_draining}, 32'd1);
      release_rd(5'd9);
      #1;
      chk("fl_inflight0", {25'd0, o_inflight_cnt}, 32'd0);
      chk("fl_drain_zero", {31'd0, o_draining}, 32'd1);
      tick();
      chk("fl_back_run", {31'd0, o_draining}, 32'd0);
      chk("fl_ready_back", {31'd0, o_issue_ready}, 32'd1);

      // Flush with nothing in flight still spends one cycle draining
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      #1;
      chk("fl0_draining", {31'd0, o_draining}, 32'd1);
      tick();
      chk("fl0_run", {31'd0, o_draining}, 32'd0);

      // Sticky error from releasing an idle register
      release_rd(5'd12);
      #1;
      chk("err_set", {31'd0, o_err}, 32'd1);
      issue(5'd2); release_rd(5'd2);
      #1;
      chk("err_sticky", {31'd0, o_err}, 32'd1);
      chk("err_traffic_cnt", {25'd0, o_inflight_cnt}, 32'd0);

      // Async reset in the middle of DRAIN with four writers pending
      issue(5'd4); issue(5'd6); issue(5'd8); issue(5'd10);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      i_rs1_idx = 5'd4;
      #1;
      chk("ar_draining", {31'd0, o_draining}, 32'd1);
      chk("ar_inflight4", {25'd0, o_inflight_cnt}, 32'd4);
      chk("ar_haz", {31'd0, o_rs1_hazard}, 32'd1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_reset_vals("ar");
      tick();
      i_rst_n = 1'b1;
      i_rs1_idx = 5'd0;
      release_rd(5'd4);
      #1;
      chk("ar_stale_release_err", {31'd0, o_err}, 32'd1);
      chk("ar_stale_inflight", {25'd0, o_inflight_cnt}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
